photonic_output_packer: RTL and testbench

Receive-side packer at the tail of the photonic layer chain. Accepts the valid-only PRECISION-bit sample stream from the last photonic layer, which has no backpressure. Packs LANES samples per OUT_WIDTH-bit word, marks the word that closes each frame of FRAME_SIZE samples, and buffers words in a small FIFO for a host-side ready/valid consumer. Loss is never silent: a sticky overflow flag records every dropped word.

---
 rtl/photonic_pkg.sv | 13 +
 rtl/photonic_sync_fifo.sv | 55 +++++
 rtl/photonic_output_packer.sv | 109 ++++++++++
 tb/tb_photonic_output_packer.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/photonic_pkg.sv
// Constants and the packed output-word type shared by the photonic layer chain and the output packer.
package photonic_pkg;

    localparam int PRECISION  = 8;
    localparam int OUT_WIDTH  = 32;
    localparam int FRAME_SIZE = 128;

    typedef struct packed {
        logic                 last;
        logic [OUT_WIDTH-1:0] data;
    } out_word_t;

endpackage

// File: rtl/photonic_sync_fifo.sv
// Generic show-ahead synchronous FIFO: the head entry is visible on rd_data whenever empty=0.
module photonic_sync_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;

    assign full  = (count_reg == CNT_W'(DEPTH));
    assign empty = (count_reg == '0);
    // Idle output is held at zero so the port never shows uninitialised storage.
    assign rd_data = empty ? '0 : mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/photonic_output_packer.sv
// Packs the valid-only sample stream into LANES-wide words, tags frame ends and buffers them
// for a ready/valid host; dropped words are recorded in a sticky overflow flag.
module photonic_output_packer
    import photonic_pkg::*;
#(
    parameter int PRECISION  = photonic_pkg::PRECISION,
    parameter int OUT_WIDTH  = photonic_pkg::OUT_WIDTH,
    parameter int FRAME_SIZE = photonic_pkg::FRAME_SIZE,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [PRECISION-1:0] s_data,
    input  logic                 s_valid,
    output logic [OUT_WIDTH-1:0] m_data,
    output logic                 m_last,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic                 overflow,
    input  logic                 clear_overflow,
    output logic [15:0]          frames_done
);

    localparam int LANES  = OUT_WIDTH / PRECISION;
    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int SAMP_W = (FRAME_SIZE > 1) ? $clog2(FRAME_SIZE) : 1;

    logic [LANE_W-1:0]    lane_cnt_reg;
    logic [SAMP_W-1:0]    samp_cnt_reg;
    logic [OUT_WIDTH-1:0] asm_reg;
    logic [OUT_WIDTH-1:0] word_next;
    logic                 overflow_reg;
    logic [15:0]          frames_done_reg;

    logic      frame_end;
    logic      complete;
    logic      fifo_full;
    logic      fifo_empty;
    logic      pop;
    logic      push;
    logic      drop;
    out_word_t wr_word;
    out_word_t rd_word;

    // Lanes above the current one are already zero because the assembly register is
    // cleared after every push or drop, which gives the zero fill of short frame-end words.
    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            assign word_next[gi*PRECISION +: PRECISION] =
                (lane_cnt_reg == LANE_W'(gi)) ? s_data : asm_reg[gi*PRECISION +: PRECISION];
        end
    endgenerate

    assign frame_end = s_valid && (samp_cnt_reg == SAMP_W'(FRAME_SIZE - 1));
    assign complete  = s_valid && ((lane_cnt_reg == LANE_W'(LANES - 1)) || frame_end);
    assign pop       = !fifo_empty && m_ready;
    // A full FIFO still accepts when the head leaves on the same edge.
    assign push      = complete && (!fifo_full || pop);
    assign drop      = complete && !push;

    assign wr_word.last = frame_end;
    assign wr_word.data = word_next;

    photonic_sync_fifo #(
        .WIDTH ($bits(out_word_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push),
        .wr_data (wr_word),
        .pop     (pop),
        .rd_data (rd_word),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane_cnt_reg    <= '0;
            samp_cnt_reg    <= '0;
            asm_reg         <= '0;
            overflow_reg    <= 1'b0;
            frames_done_reg <= '0;
        end else begin
            if (s_valid) begin
                lane_cnt_reg <= complete  ? '0 : lane_cnt_reg + LANE_W'(1);
                samp_cnt_reg <= frame_end ? '0 : samp_cnt_reg + SAMP_W'(1);
                asm_reg      <= complete  ? '0 : word_next;
            end
            if (drop) begin
                overflow_reg <= 1'b1;
            end else if (clear_overflow) begin
                overflow_reg <= 1'b0;
            end
            if (frame_end) begin
                frames_done_reg <= frames_done_reg + 16'd1;
            end
        end
    end

    assign m_data      = rd_word.data;
    assign m_last      = rd_word.last;
    assign m_valid     = !fifo_empty;
    assign overflow    = overflow_reg;
    assign frames_done = frames_done_reg;

endmodule

// File: tb/tb_photonic_output_packer.sv
// Directed and randomized checks of photonic_output_packer against a queue-based reference model.
module tb_photonic_output_packer;

    localparam int LANES = 4;
    localparam int FS    = 128;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  s_data;
    logic        s_valid;
    logic [31:0] m_data;
    logic        m_last;
    logic        m_valid;
    logic        m_ready;
    logic        overflow;
    logic        clear_overflow;
    logic [15:0] frames_done;

    logic [7:0]  b_s_data;
    logic        b_s_valid;
    logic [31:0] b_m_data;
    logic        b_m_last;
    logic        b_m_valid;
    logic        b_m_ready;
    logic        b_overflow;
    logic [15:0] b_frames_done;

    always #5 clk = ~clk;

    photonic_output_packer dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .s_data         (s_data),
        .s_valid        (s_valid),
        .m_data         (m_data),
        .m_last         (m_last),
        .m_valid        (m_valid),
        .m_ready        (m_ready),
        .overflow       (overflow),
        .clear_overflow (clear_overflow),
        .frames_done    (frames_done)
    );

    photonic_output_packer #(.FRAME_SIZE(6)) dut_short (
        .clk            (clk),
        .rst_n          (rst_n),
        .s_data         (b_s_data),
        .s_valid        (b_s_valid),
        .m_data         (b_m_data),
        .m_last         (b_m_last),
        .m_valid        (b_m_valid),
        .m_ready        (b_m_ready),
        .overflow       (b_overflow),
        .clear_overflow (1'b0),
        .frames_done    (b_frames_done)
    );

    typedef struct {
        logic [31:0] data;
        logic        last;
    } exp_t;

    exp_t        q[$];
    logic [7:0]  cur[$];
    int          pos;
    int          frames;
    logic        ovf;
    int          pushed;
    int          drained;
    logic        prev_stall;
    logic [31:0] prev_data;
    int          errors = 0;
    int          checks = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        q.delete();
        cur.delete();
        pos = 0;
        frames = 0;
        ovf = 1'b0;
        pushed = 0;
        drained = 0;
        prev_stall = 1'b0;
        prev_data = '0;
    endtask

    task automatic check_outputs();
        chk("m_valid", 64'(m_valid), 64'(q.size() != 0));
        if (q.size() != 0) begin
            chk("m_data", 64'(m_data), 64'(q[0].data));
            chk("m_last", 64'(m_last), 64'(q[0].last));
        end
        if (prev_stall) begin
            chk("stall_stable", 64'(m_data), 64'(prev_data));
        end
        chk("overflow", 64'(overflow), 64'(ovf));
        chk("frames_done", 64'(frames_done), 64'(frames[15:0]));
    endtask

    // One clock: check model vs DUT at negedge, drive, advance the model on the edge.
    task automatic cycle(input logic v, input logic [7:0] d, input logic rdy, input logic clr);
        logic        pop;
        logic        fe;
        logic        drop;
        logic [31:0] w;
        @(negedge clk);
        check_outputs();
        s_valid = v;
        s_data = d;
        m_ready = rdy;
        clear_overflow = clr;
        if (m_valid && rdy) drained++;
        prev_stall = m_valid && !rdy;
        prev_data = m_data;
        pop = rdy && (q.size() != 0);
        @(posedge clk);
        drop = 1'b0;
        if (pop) q.delete(0);
        if (v) begin
            cur.push_back(d);
            pos++;
            fe = (pos == FS);
            if (fe) begin
                pos = 0;
                frames++;
            end
            if (fe || cur.size() == LANES) begin
                w = '0;
                foreach (cur[i]) w[8*i +: 8] = cur[i];
                if (q.size() < DEPTH) begin
                    q.push_back('{w, fe});
                    pushed++;
                end else begin
                    drop = 1'b1;
                end
                cur.delete();
            end
        end
        if (drop) ovf = 1'b1;
        else if (clr) ovf = 1'b0;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        s_valid = 1'b0;
        s_data = '0;
        m_ready = 1'b0;
        clear_overflow = 1'b0;
        b_s_valid = 1'b0;
        b_s_data = '0;
        b_m_ready = 1'b0;
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b1;
        do_reset();

        // Reset state
        chk("rst_m_valid", 64'(m_valid), 64'd0);
        chk("rst_m_data", 64'(m_data), 64'd0);
        chk("rst_m_last", 64'(m_last), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        chk("rst_frames_done", 64'(frames_done), 64'd0);

        // Packing
        for (int i = 1; i <= 8; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0);
        chk("pack_word0", 64'(m_data), 64'h04030201);
        chk("pack_last0", 64'(m_last), 64'd0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        chk("pack_word1", 64'(m_data), 64'h08070605);
        chk("pack_last1", 64'(m_last), 64'd0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);

        // Short frame on the FRAME_SIZE=6 instance
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            b_s_valid = 1'b1;
            b_s_data = 8'h11 + 8'(i);
        end
        @(negedge clk);
        b_s_valid = 1'b0;
        chk("short_word0", 64'(b_m_data), 64'h14131211);
        chk("short_last0", 64'(b_m_last), 64'd0);
        chk("short_frames", 64'(b_frames_done), 64'd1);
        b_m_ready = 1'b1;
        @(negedge clk);
        chk("short_word1", 64'(b_m_data), 64'h00001615);
        chk("short_last1", 64'(b_m_last), 64'd1);
        @(negedge clk);
        b_m_ready = 1'b0;
        chk("short_empty", 64'(b_m_valid), 64'd0);

        // Overflow: nine words into an eight-deep FIFO
        do_reset();
        for (int i = 0; i < 36; i++) cycle(1'b1, 8'($urandom), 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        chk("ovf_set", 64'(overflow), 64'd1);
        drained = 0;
        repeat (12) cycle(1'b0, 8'h00, 1'b1, 1'b0);
        chk("ovf_drain_count", 64'(drained), 64'd8);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        chk("ovf_cleared", 64'(overflow), 64'd0);

        // Same-cycle pop on a full FIFO
        do_reset();
        for (int i = 0; i < 35; i++) cycle(1'b1, 8'($urandom), 1'b0, 1'b0);
        cycle(1'b1, 8'($urandom), 1'b1, 1'b0);
        chk("samepop_no_ovf", 64'(overflow), 64'd0);
        drained = 0;
        repeat (12) cycle(1'b0, 8'h00, 1'b1, 1'b0);
        chk("samepop_count", 64'(drained), 64'd8);

        // Random backpressure, stream below capacity
        do_reset();
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 9) < 6), 8'($urandom), 1'($urandom_range(0, 9) < 7), 1'b0);
        end
        repeat (20) cycle(1'b0, 8'h00, 1'b1, 1'b0);
        chk("bp_no_loss", 64'(drained), 64'(pushed));
        chk("bp_no_ovf", 64'(overflow), 64'd0);

        // Reset mid-word
        do_reset();
        cycle(1'b1, 8'h55, 1'b0, 1'b0);
        cycle(1'b1, 8'h66, 1'b0, 1'b0);
        do_reset();
        for (int i = 0; i < 4; i++) cycle(1'b1, 8'hA1 + 8'(i), 1'b0, 1'b0);
        chk("rstmid_word", 64'(m_data), 64'hA4A3A2A1);
        chk("rstmid_frames", 64'(frames_done), 64'd0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        chk("rstmid_single", 64'(m_valid), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
